// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment type, off pattern and hex glyph table.
// All patterns are active-high in {g,f,e,d,c,b,a} order.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hexToSeg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high 7-segment glyph (full 0-F).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       segs
);

  always_comb segs = hexToSeg(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with a blank cycle at the
// start of every digit slot, leading-zero blanking, blank mask and dp.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1,
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic [4*NUM_DIGITS-1:0] digitsIn,
  input  logic [NUM_DIGITS-1:0]   dpIn,
  input  logic [NUM_DIGITS-1:0]   blankMask,
  input  logic                    leadZeroBlank,
  input  logic                    load,
  output logic [6:0]              segs,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [IDX_W-1:0]        scanIdx
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        scan_q, scan_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    lzb_q, lzb_d;

  logic                    cnt_wrap;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    upper_zero;
  int unsigned             idx;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_mask, cur_lz;
  seg_t                    dec_segs;
  logic                    slot_active;
  seg_t                    seg_on;
  logic                    dp_on;
  logic [NUM_DIGITS-1:0]   an_on;

  always_comb begin
    cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    scan_d   = scan_q;
    if (cnt_wrap) begin
      scan_d = (scan_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_q + IDX_W'(1);
    end
    digits_d = load ? digitsIn      : digits_q;
    dp_d     = load ? dpIn          : dp_q;
    mask_d   = load ? blankMask     : mask_q;
    lzb_d    = load ? leadZeroBlank : lzb_q;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q    <= '0;
      scan_q   <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      mask_q   <= '0;
      lzb_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      scan_q   <= scan_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      mask_q   <= mask_d;
      lzb_q    <= lzb_d;
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero
  // while every digit at or above it is zero. Digit 0 always stays lit.
  always_comb begin
    upper_zero = 1'b1;
    lead_zero  = '0;
    idx        = 0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      idx            = NUM_DIGITS - 1 - j;
      upper_zero     = upper_zero && (digits_q[4*idx +: 4] == 4'h0);
      lead_zero[idx] = lzb_q && upper_zero && (idx != 0);
    end
  end

  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_mask = 1'b0;
    cur_lz   = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == IDX_W'(i)) begin
        cur_nib  = digits_q[4*i +: 4];
        cur_dp   = dp_q[i];
        cur_mask = mask_q[i];
        cur_lz   = lead_zero[i];
      end
    end
  end

  seg_hex_decode u_hex_decode (
    .nibble (cur_nib),
    .segs   (dec_segs)
  );

  always_comb begin
    slot_active = (cnt_q != '0);
    seg_on      = (slot_active && !cur_mask && !cur_lz) ? dec_segs : SEG_OFF;
    dp_on       = slot_active && cur_dp && !cur_mask;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      an_on[i] = slot_active && (scan_q == IDX_W'(i));
    end
    segs    = ACTIVE_LOW_SEG ? ~seg_on : seg_on;
    dp      = ACTIVE_LOW_SEG ? ~dp_on  : dp_on;
    anodes  = ACTIVE_LOW_AN  ? ~an_on  : an_on;
    scanIdx = scan_q;
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a time-based display model.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        nReset;
  logic [15:0] digitsIn;
  logic [3:0]  dpIn, blankMask;
  logic        leadZeroBlank, load;
  logic [6:0]  segs;
  logic        dp;
  logic [3:0]  anodes;
  logic [1:0]  scanIdx;

  int checks   = 0;
  int failures = 0;

  // Model: edges since reset release plus the last captured load values.
  int unsigned cyc;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_mask;
  logic        m_lzb;
  logic [6:0]  glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg_scan_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk           (clk),
    .nReset        (nReset),
    .digitsIn      (digitsIn),
    .dpIn          (dpIn),
    .blankMask     (blankMask),
    .leadZeroBlank (leadZeroBlank),
    .load          (load),
    .segs          (segs),
    .dp            (dp),
    .anodes        (anodes),
    .scanIdx       (scanIdx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic check_outputs();
    int unsigned phase, slot;
    logic [3:0]  nib;
    logic        dark;
    logic [6:0]  e_seg, e_seg_pin;
    logic        e_dp, e_dp_pin;
    logic [3:0]  e_an, e_an_pin;
    phase = cyc % RD;
    slot  = (cyc / RD) % ND;
    nib   = 4'((m_val >> (4 * slot)) & 16'hF);
    dark  = m_mask[slot] || (m_lzb && slot != 0 && (m_val >> (4 * slot)) == 0);
    if (phase == 0) begin
      e_seg = 7'h00; e_dp = 1'b0; e_an = 4'h0;
    end else begin
      e_seg = dark ? 7'h00 : glyph[nib];
      e_dp  = m_dp[slot] && !m_mask[slot];
      e_an  = 4'(1 << slot);
    end
    e_seg_pin = ~e_seg;
    e_dp_pin  = ~e_dp;
    e_an_pin  = ~e_an;
    check("segs",    segs,    e_seg_pin);
    check("dp",      dp,      e_dp_pin);
    check("anodes",  anodes,  e_an_pin);
    check("scanIdx", scanIdx, slot);
  endtask

  task automatic model_reset();
    cyc = 0; m_val = '0; m_dp = '0; m_mask = '0; m_lzb = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    if (nReset) begin
      if (load) begin
        m_val = digitsIn; m_dp = dpIn; m_mask = blankMask; m_lzb = leadZeroBlank;
      end
      cyc++;
    end
    #1;
    check_outputs();
  endtask

  task automatic load_value(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] m, input logic z, input int cycles);
    digitsIn = v; dpIn = d; blankMask = m; leadZeroBlank = z; load = 1'b1;
    step();
    load = 1'b0;
    repeat (cycles) step();
  endtask

  // Called just after a checked edge; reset lands mid-cycle and must blank at once.
  task automatic do_reset();
    #2;
    nReset = 1'b0;
    load   = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step();
    @(negedge clk);
    nReset = 1'b1;
    check_outputs();
  endtask

  initial begin
    nReset = 1'b0; digitsIn = '0; dpIn = '0; blankMask = '0;
    leadZeroBlank = 1'b0; load = 1'b0;
    model_reset();
    #1;
    check_outputs();
    step();
    step();
    @(negedge clk);
    nReset = 1'b1;
    check_outputs();
    repeat (5) step();

    load_value(16'h1234, 4'h0, 4'h0, 1'b0, 20);
    load_value(16'hABCD, 4'h0, 4'h0, 1'b0, 16);
    load_value(16'h0050, 4'h0, 4'h0, 1'b1, 16);
    load_value(16'h0050, 4'h0, 4'h0, 1'b0, 16);
    load_value(16'h8888, 4'b0100, 4'b0010, 1'b0, 16);

    while (cyc % RD != 3) step();
    load_value(16'h9999, 4'h0, 4'h0, 1'b0, 1);
    check("boundary_load", segs, 7'h10);

    while (cyc % RD != 2) step();
    do_reset();
    repeat (6) step();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        digitsIn      = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dpIn          = 4'($urandom);
        blankMask     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
        leadZeroBlank = 1'($urandom);
        load          = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display driver. Successor to the single-digit decoder.
- Captures NUM_DIGITS hex nibbles into a shadow register and scans one digit at a time, with a blanking slot between digits to prevent ghosting.
- Adds full hex decode (0-F), leading-zero blanking, per-digit blank mask and decimal points.
- Sits between the value/parser logic and the board's shared segment bus and anode enables.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= 2.
- ACTIVE_LOW_SEG, 1: when 1, segs and dp are driven active-low.
- ACTIVE_LOW_AN, 1: when 1, anodes are driven active-low.

Ports:
- clk  in  1  system clock.
- nReset  in  1  asynchronous, active-low reset.
- digitsIn  in  4*NUM_DIGITS  hex nibbles; digit i is bits [4i+3:4i]; digit 0 is rightmost.
- dpIn  in  NUM_DIGITS  decimal point request per digit.
- blankMask  in  NUM_DIGITS  1 forces that digit dark.
- leadZeroBlank  in  1  enables suppression of leading zeros.
- load  in  1  captures digitsIn/dpIn/blankMask/leadZeroBlank into the shadow register.
- segs  out  7  segments {g,f,e,d,c,b,a} for the current digit.
- dp  out  1  decimal point for the current digit.
- anodes  out  NUM_DIGITS  one-hot digit enable.
- scanIdx  out  $clog2(NUM_DIGITS) (min 1)  index of the digit slot currently scanned.

Behaviour:
- Reset (async, nReset=0):
  - Shadow register, prescaler count, and scanIdx all cleared to 0.
  - segs, dp and anodes immediately go to their inactive level: all segments off, all anodes off.
  - Reset mid-scan abandons the slot. After release, scanning restarts at slot 0, cycle 0.
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps.
  - On the edge where cnt==REFRESH_DIV-1, scanIdx advances. It wraps from NUM_DIGITS-1 to 0.
  - A slot therefore lasts exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Blanking slot: while cnt==0, all anodes are inactive and segs/dp are off. For cnt 1..REFRESH_DIV-1, only anodes[scanIdx] is active.
- Load:
  - Sampled on the rising edge. The shadow register takes the new values at that edge.
  - Outputs reflect the new data from the following cycle; there is no mid-slot tearing beyond that edge.
  - Without load, the shadow register holds its contents indefinitely.
- Simultaneous load and slot boundary on the same edge: both take effect. The new slot displays the new data.
- Output timing: outputs are combinational decode of registered state (shadow, cnt, scanIdx) only. There is no combinational path from any input to any output.
- Hex decode (active-high, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - The table is complete; no default-latch case exists.
- Digit dark conditions: a digit is dark (segs off) if its blankMask bit is 1, or if it is a leading zero.
  - Leading zero means: leadZeroBlank=1, and the digit and all higher-index digits are 0.
  - Digit 0 is never leading-zero blanked.
- dp is driven from dpIn for the current digit and is independent of digit darkness. blankMask forces dp off.
- Polarity: ACTIVE_LOW_SEG inverts segs and dp at the output. ACTIVE_LOW_AN inverts anodes. Inactive level follows polarity.

Decomposition:
- Package seg_pkg holds:
  - SEG_OFF constant and the 16-entry hex-to-segment table, as a localparam array.
  - Function hexToSeg(nibble) returning 7 bits, active-high.
  - Typedef seg_t (logic [6:0]).
- One sub-module, seg_hex_decode: purely combinational nibble-to-segments wrapper around hexToSeg. It is reused by other display blocks.
- Prescaler, scan counter, shadow register and blanking logic stay in seg_scan_driver.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, both polarities active-low):
- Reset: assert nReset=0 mid-slot → same cycle segs=7F, dp=1, anodes=F. After release, scanIdx=0 and the first active anode (1110) appears on cycle 1.
- Scan/wrap: load digitsIn=16'h1234, dpIn=0.
  - Digit 0 shows ~4=19 with anodes=1110, then digits 1, 2, 3 in order.
  - Each slot is 4 cycles with 1 blank cycle. After digit 3, scanIdx returns to 0.
- Hex/A-F: load 16'hABCD → segs per slot = ~5E, ~39, ~7C, ~77, i.e. 21, 46, 03, 08.
- Leading zeros: load 16'h0050 with leadZeroBlank=1.
  - Digits 3 and 2 are dark (7F); digit 1 = ~6D = 12; digit 0 = ~3F = 40.
  - With leadZeroBlank=0, digit 3 shows 40.
- Mask/dp: load blankMask=4'b0010, dpIn=4'b0100, value 16'h8888.
  - Digit 1 is dark with dp off; digit 2 shows 00 with dp=0.
- Load at boundary: pulse load with 16'h9999 on the edge where cnt==3 → the next slot's first active cycle shows ~6F = 10.
